// File: rtl/onehot_serial_encoder_pkg.sv
// Shared definitions for the one-hot serial encoder: FSM state encoding
// and an elaboration-time ceil(log2) helper for deriving index widths.
package onehot_serial_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic int clog2f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_serial_encoder_prio_enc.sv
// Combinational priority encoder: index of the lowest (LSB_FIRST=1) or highest
// set bit, plus any/single flags. Output is defined for zero and multi-hot input.
module prio_enc
  import onehot_serial_encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W        = clog2f(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  // The last matching iteration wins, so scan toward the priority end.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/onehot_serial_encoder.sv
// Registered request-vector serialiser: captures an N-bit vector and streams the
// index of each set bit in priority order over a valid/ready output.
module onehot_serial_encoder
  import onehot_serial_encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W        = clog2f(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_multi,
  output logic         err_zero
);

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_pending;
  logic           r_multi;
  logic           r_err_zero;
  logic [N-1:0]   w_clear_mask;
  logic [W-1:0]   w_idx;
  logic           w_any;
  logic           w_single;
  logic           w_accept;
  logic           w_beat;
  logic           w_vec_zero;

  prio_enc #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_prio_enc (
    .vec    (r_pending),
    .idx    (w_idx),
    .any    (w_any),
    .single (w_single)
  );

  assign in_ready     = (r_state == ST_IDLE);
  assign out_valid    = (r_state == ST_SCAN) && w_any;
  assign out_idx      = w_idx;
  assign out_last     = w_single;
  assign out_multi    = r_multi;
  assign err_zero     = r_err_zero;
  assign w_accept     = in_valid && in_ready;
  assign w_beat       = out_valid && out_ready;
  assign w_vec_zero   = (in_vec == '0);
  assign w_clear_mask = N'(1) << w_idx;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_vec_zero) w_state_next = ST_SCAN;
      ST_SCAN: if (w_beat && w_single) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A completed beat retires exactly the bit that was just presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_multi    <= 1'b0;
      r_err_zero <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_err_zero <= w_accept && w_vec_zero;
      if (w_accept && !w_vec_zero) begin
        r_pending <= in_vec;
        r_multi   <= ((in_vec & (in_vec - N'(1))) != '0);
      end else if (w_beat) begin
        r_pending <= r_pending & ~w_clear_mask;
      end
    end
  end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Randomised self-checking bench: three encoder configurations checked against
// an index-list reference model built from each accepted vector.
module tb_onehot_serial_encoder;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] inValid;
  logic [7:0] inVec;
  logic       outReady;

  logic       inReadyA  [3];
  logic       outValidA [3];
  logic       outLastA  [3];
  logic       outMultiA [3];
  logic       errZeroA  [3];
  logic [2:0] outIdxA   [3];

  int total = 0;
  int bad   = 0;
  int sel;
  int nBits;
  bit lsbFirst;
  int expMulti [3];

  always #5 clk = ~clk;

  onehot_serial_encoder #(.N(8), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[0]), .in_ready(inReadyA[0]),
    .in_vec(inVec), .out_valid(outValidA[0]), .out_ready(outReady),
    .out_idx(outIdxA[0]), .out_last(outLastA[0]), .out_multi(outMultiA[0]),
    .err_zero(errZeroA[0])
  );

  onehot_serial_encoder #(.N(8), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[1]), .in_ready(inReadyA[1]),
    .in_vec(inVec), .out_valid(outValidA[1]), .out_ready(outReady),
    .out_idx(outIdxA[1]), .out_last(outLastA[1]), .out_multi(outMultiA[1]),
    .err_zero(errZeroA[1])
  );

  onehot_serial_encoder #(.N(5), .LSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[2]), .in_ready(inReadyA[2]),
    .in_vec(inVec[4:0]), .out_valid(outValidA[2]), .out_ready(outReady),
    .out_idx(outIdxA[2]), .out_last(outLastA[2]), .out_multi(outMultiA[2]),
    .err_zero(errZeroA[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (dut%0d, t=%0t)",
               tag, observed, expected, sel, $time);
    end
  endtask

  task automatic resetAll();
    rstN     = 1'b0;
    inValid  = '0;
    outReady = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) expMulti[i] = 0;
  endtask

  // readyMode: 0 = always ready, 1 = random ready, 2 = stall first three cycles
  task automatic applyStimulus(input logic [7:0] v, input int readyMode);
    int q[$];
    int waitCnt;
    int cycles;
    int cnt;
    waitCnt = 0;
    while (inReadyA[sel] !== 1'b1 && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 20) checkOutput("readyTimeout", 0, 1);
    for (int i = 0; i < nBits; i++) begin
      if (v[i]) begin
        if (lsbFirst) q.push_back(i);
        else          q.push_front(i);
      end
    end
    cnt = q.size();
    inValid[sel] = 1'b1;
    inVec        = v;
    @(posedge clk); #1;
    inValid = '0;
    inVec   = 8'($urandom);
    if (cnt == 0) begin
      checkOutput("errZeroPulse", 32'(errZeroA[sel]), 1);
      checkOutput("zeroNoValid", 32'(outValidA[sel]), 0);
      checkOutput("zeroMultiHold", 32'(outMultiA[sel]), expMulti[sel]);
      checkOutput("zeroReady", 32'(inReadyA[sel]), 1);
    end else begin
      expMulti[sel] = (cnt > 1) ? 1 : 0;
      cycles = 0;
      while (q.size() > 0 && cycles < 200) begin
        checkOutput("outValid", 32'(outValidA[sel]), 1);
        checkOutput("outIdx", 32'(outIdxA[sel]), q[0]);
        checkOutput("outLast", 32'(outLastA[sel]), (q.size() == 1) ? 1 : 0);
        checkOutput("outMulti", 32'(outMultiA[sel]), expMulti[sel]);
        checkOutput("inReadyBusy", 32'(inReadyA[sel]), 0);
        checkOutput("errZeroQuiet", 32'(errZeroA[sel]), 0);
        case (readyMode)
          0:       outReady = 1'b1;
          1:       outReady = 1'($urandom_range(0, 1));
          default: outReady = (cycles >= 3);
        endcase
        @(posedge clk); #1;
        inVec = 8'($urandom);
        if (outReady) void'(q.pop_front());
        cycles++;
      end
      if (q.size() > 0) checkOutput("scanTimeout", q.size(), 0);
      checkOutput("doneNoValid", 32'(outValidA[sel]), 0);
      checkOutput("doneReady", 32'(inReadyA[sel]), 1);
    end
  endtask

  task automatic randomRun(input int count);
    logic [7:0] v;
    logic [7:0] mask;
    mask = (nBits == 8) ? 8'hFF : 8'h1F;
    for (int n = 0; n < count; n++) begin
      v = 8'($urandom_range(0, 255)) & mask;
      if ($urandom_range(0, 5) == 0) v = 8'h00;
      applyStimulus(v, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN     = 1'b0;
    inValid  = '0;
    inVec    = 8'h00;
    outReady = 1'b0;
    sel      = 0;
    nBits    = 8;
    lsbFirst = 1'b1;
    for (int i = 0; i < 3; i++) expMulti[i] = 0;

    // Vector presented during reset must never be captured.
    inValid[0] = 1'b1;
    inVec      = 8'h81;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("rstNoValid", 32'(outValidA[0]), 0);
      checkOutput("rstNoErr", 32'(errZeroA[0]), 0);
    end
    rstN    = 1'b1;
    inValid = '0;
    @(posedge clk); #1;
    checkOutput("rstReleaseReady", 32'(inReadyA[0]), 1);
    checkOutput("rstReleaseNoValid", 32'(outValidA[0]), 0);
    checkOutput("rstMulti", 32'(outMultiA[0]), 0);
    @(posedge clk); #1;
    checkOutput("rstNoBeat", 32'(outValidA[0]), 0);

    applyStimulus(8'b0010_0000, 0);
    applyStimulus(8'b1000_0101, 0);
    applyStimulus(8'h06, 2);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h10, 0);
    randomRun(25);

    sel      = 1;
    lsbFirst = 1'b0;
    resetAll();
    applyStimulus(8'b1000_0101, 0);
    applyStimulus(8'h00, 0);
    randomRun(25);

    sel      = 2;
    nBits    = 5;
    lsbFirst = 1'b1;
    resetAll();
    applyStimulus(8'h10, 0);
    inValid[2] = 1'b1;
    inVec      = 8'h1F;
    @(posedge clk); #1;
    inValid = '0;
    checkOutput("midValid", 32'(outValidA[2]), 1);
    checkOutput("midIdx0", 32'(outIdxA[2]), 0);
    outReady = 1'b1;
    rstN     = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    expMulti[2] = 0;
    checkOutput("midRstNoValid", 32'(outValidA[2]), 0);
    checkOutput("midRstMulti", 32'(outMultiA[2]), 0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("midRstNoBeat", 32'(outValidA[2]), 0);
      checkOutput("midRstReady", 32'(inReadyA[2]), 1);
    end
    randomRun(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
